icc_branch_unit: RTL and testbench

Integer-condition-code register and branch resolver for the SPARC-style pipeline, sitting on the consumer side of the 32-bit ALU. It latches the N/Z/C/V flags that the ALU produces for flag-setting (S-bit) opcodes, and it feeds the stored carry back to the ALU for the carry-using opcodes. It evaluates the 16 Bicc conditions, with bypass, against the flags, and it tracks the delay slot, including annulment, through a two-state machine.

---
 rtl/icc_pkg.sv | 38 +++
 rtl/icc_cond_eval.sv | 33 +++
 rtl/icc_branch_unit.sv | 103 ++++++++++
 tb/tb_icc_branch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/icc_pkg.sv
// Shared definitions for the integer condition codes: flag layout, Bicc/Ticc
// condition encodings and the ALU opcode bits that control flag writes.
package icc_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } icc_t;

    localparam logic [3:0] COND_N   = 4'h0;
    localparam logic [3:0] COND_E   = 4'h1;
    localparam logic [3:0] COND_LE  = 4'h2;
    localparam logic [3:0] COND_L   = 4'h3;
    localparam logic [3:0] COND_LEU = 4'h4;
    localparam logic [3:0] COND_CS  = 4'h5;
    localparam logic [3:0] COND_NEG = 4'h6;
    localparam logic [3:0] COND_VS  = 4'h7;
    localparam logic [3:0] COND_A   = 4'h8;
    localparam logic [3:0] COND_NE  = 4'h9;
    localparam logic [3:0] COND_G   = 4'hA;
    localparam logic [3:0] COND_GE  = 4'hB;
    localparam logic [3:0] COND_GU  = 4'hC;
    localparam logic [3:0] COND_CC  = 4'hD;
    localparam logic [3:0] COND_POS = 4'hE;
    localparam logic [3:0] COND_VC  = 4'hF;

    localparam int OPC_SHIFT = 5;
    localparam int OPC_S     = 4;
    localparam int OPC_CARRY = 3;

    // Only non-shift opcodes carrying the S bit are allowed to update the flags.
    function automatic logic icc_writes(input logic [5:0] opcode);
        return ~opcode[OPC_SHIFT] & opcode[OPC_S];
    endfunction

endpackage

// File: rtl/icc_cond_eval.sv
// Combinational Bicc/Ticc condition evaluator: cond[3] inverts the base test
// selected by cond[2:0], which makes 0 "never" and 8 "always".
module icc_cond_eval
    import icc_pkg::*;
(
    input  logic [3:0] icc_i,
    input  logic [3:0] cond_i,
    output logic       taken_o
);

    icc_t flags;
    logic baseTest;

    assign flags = icc_t'(icc_i);

    always_comb begin
        baseTest = 1'b0;
        case (cond_i[2:0])
            3'd0: baseTest = 1'b0;
            3'd1: baseTest = flags.z;
            3'd2: baseTest = flags.z | (flags.n ^ flags.v);
            3'd3: baseTest = flags.n ^ flags.v;
            3'd4: baseTest = flags.c | flags.z;
            3'd5: baseTest = flags.c;
            3'd6: baseTest = flags.n;
            3'd7: baseTest = flags.v;
            default: baseTest = 1'b0;
        endcase
    end

    assign taken_o = cond_i[3] ^ baseTest;

endmodule

// File: rtl/icc_branch_unit.sv
// Condition-code register plus Bicc resolver with same-cycle flag bypass and a
// two-state delay-slot tracker handling annulment and DCTI couples.
module icc_branch_unit
    import icc_pkg::*;
#(
    parameter int ICC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [5:0]       alu_opcode,
    input  logic [ICC_W-1:0] alu_icc,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    input  logic             br_annul,
    output logic [ICC_W-1:0] icc,
    output logic             carry,
    output logic             br_taken,
    output logic             slot_pending,
    output logic             br_squash,
    output logic             dcti_err
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SLOT = 1'b1;

    logic state_q, state_d;
    icc_t icc_q, icc_d;
    logic taken_q, taken_d;
    logic squash_q, squash_d;
    logic dcti_q, dcti_d;

    logic inSlot;
    logic squashNow;
    logic wrIcc;
    icc_t effIcc;
    logic condTaken;
    logic annulSlot;
    logic slotConsumed;
    logic dctiCouple;
    logic brAccept;
    logic [3:0] unusedOpcodeBits;

    assign unusedOpcodeBits = alu_opcode[3:0];

    assign inSlot    = (state_q == STATE_SLOT);
    assign squashNow = squash_q & inSlot;
    assign wrIcc     = alu_valid & icc_writes(alu_opcode) & ~squashNow;

    // The same-cycle ALU op is older than the branch, so its flags win.
    assign effIcc = wrIcc ? icc_t'(alu_icc) : icc_q;

    icc_cond_eval u_cond_eval (
        .icc_i  (effIcc),
        .cond_i (br_cond),
        .taken_o(condTaken)
    );

    assign annulSlot    = br_annul & (~condTaken | (br_cond == COND_A));
    assign slotConsumed = inSlot & (alu_valid | br_valid);
    assign dctiCouple   = inSlot & br_valid & ~alu_valid;
    assign brAccept     = br_valid & (~inSlot | alu_valid);

    always_comb begin
        icc_d    = wrIcc ? icc_t'(alu_icc) : icc_q;
        state_d  = state_q;
        squash_d = squash_q;
        taken_d  = 1'b0;
        dcti_d   = dcti_q | dctiCouple;
        if (brAccept) begin
            state_d  = STATE_SLOT;
            squash_d = annulSlot;
            taken_d  = condTaken;
        end else if (slotConsumed) begin
            state_d  = STATE_IDLE;
            squash_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            icc_q    <= '0;
            taken_q  <= 1'b0;
            squash_q <= 1'b0;
            dcti_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            icc_q    <= icc_d;
            taken_q  <= taken_d;
            squash_q <= squash_d;
            dcti_q   <= dcti_d;
        end
    end

    assign icc          = icc_q;
    assign carry        = icc_q.c;
    assign br_taken     = taken_q;
    assign slot_pending = inSlot;
    assign br_squash    = squash_q & inSlot;
    assign dcti_err     = dcti_q;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed, table-driven bench for icc_branch_unit: one table row per clock
// cycle, followed by hand-written bubble and mid-slot reset sequences.
module tb_icc_branch_unit;

    logic       clk;
    logic       reset;
    logic       alu_valid;
    logic [5:0] alu_opcode;
    logic [3:0] alu_icc;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_annul;
    logic [3:0] icc;
    logic       carry;
    logic       br_taken;
    logic       slot_pending;
    logic       br_squash;
    logic       dcti_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       av;
        logic [5:0] op;
        logic [3:0] aicc;
        logic       bv;
        logic [3:0] cond;
        logic       ann;
        logic [3:0] eIcc;
        logic       eTaken;
        logic       ePend;
        logic       eSq;
        logic       eDcti;
    } vec_t;

    vec_t vecs[$];

    icc_branch_unit #(.ICC_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_opcode  (alu_opcode),
        .alu_icc     (alu_icc),
        .br_valid    (br_valid),
        .br_cond     (br_cond),
        .br_annul    (br_annul),
        .icc         (icc),
        .carry       (carry),
        .br_taken    (br_taken),
        .slot_pending(slot_pending),
        .br_squash   (br_squash),
        .dcti_err    (dcti_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic av, input logic [5:0] op,
                          input logic [3:0] aicc, input logic bv, input logic [3:0] cond,
                          input logic ann, input logic [3:0] eIcc, input logic eTaken,
                          input logic ePend, input logic eSq, input logic eDcti);
        vec_t v;
        v.rst = rst;  v.av = av;  v.op = op;  v.aicc = aicc;
        v.bv = bv;  v.cond = cond;  v.ann = ann;
        v.eIcc = eIcc;  v.eTaken = eTaken;  v.ePend = ePend;
        v.eSq = eSq;  v.eDcti = eDcti;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs at the falling edge, then settle past the rising edge.
    task automatic applyStimulus(input logic rst, input logic av, input logic [5:0] op,
                                 input logic [3:0] aicc, input logic bv,
                                 input logic [3:0] cond, input logic ann);
        @(negedge clk);
        reset      = rst;
        alu_valid  = av;
        alu_opcode = op;
        alu_icc    = aicc;
        br_valid   = bv;
        br_cond    = cond;
        br_annul   = ann;
        @(posedge clk);
        #1;
    endtask

    task automatic compareField(input string tag, input string field,
                                input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eIcc, input logic eTaken,
                               input logic ePend, input logic eSq, input logic eDcti);
        compareField(tag, "icc", icc, eIcc);
        compareField(tag, "carry", {3'b000, carry}, {3'b000, eIcc[1]});
        compareField(tag, "br_taken", {3'b000, br_taken}, {3'b000, eTaken});
        compareField(tag, "slot_pending", {3'b000, slot_pending}, {3'b000, ePend});
        compareField(tag, "br_squash", {3'b000, br_squash}, {3'b000, eSq});
        compareField(tag, "dcti_err", {3'b000, dcti_err}, {3'b000, eDcti});
    endtask

    initial begin
        reset = 1'b1;  alu_valid = 1'b0;  alu_opcode = '0;  alu_icc = '0;
        br_valid = 1'b0;  br_cond = '0;  br_annul = 1'b0;

        // rst av  op         aicc     bv cond   a   icc      tk pd sq de
        addVec(1, 0, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0000, 0, 0, 0, 0);
        addVec(0, 1, 6'b010000, 4'b0110, 0, 4'h0, 0,  4'b0110, 0, 0, 0, 0);
        addVec(0, 1, 6'b000000, 4'b1001, 0, 4'h0, 0,  4'b0110, 0, 0, 0, 0);
        addVec(0, 1, 6'b100101, 4'b1001, 0, 4'h0, 0,  4'b0110, 0, 0, 0, 0);
        addVec(0, 1, 6'b110000, 4'b1001, 0, 4'h0, 0,  4'b0110, 0, 0, 0, 0);
        addVec(0, 1, 6'b010000, 4'b0100, 0, 4'h0, 0,  4'b0100, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h1, 0,  4'b0100, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0100, 0, 0, 0, 0);
        addVec(0, 1, 6'b010100, 4'b1000, 1, 4'h3, 0,  4'b1000, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b1000, 0, 0, 0, 0);
        addVec(0, 1, 6'b000100, 4'b0000, 1, 4'h3, 0,  4'b1000, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b1000, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h8, 1,  4'b1000, 1, 1, 1, 0);
        addVec(0, 1, 6'b010001, 4'b0100, 0, 4'h0, 0,  4'b1000, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h1, 1,  4'b1000, 0, 1, 1, 0);
        addVec(0, 1, 6'b010000, 4'b0001, 0, 4'h0, 0,  4'b1000, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h6, 1,  4'b1000, 1, 1, 0, 0);
        addVec(0, 1, 6'b010000, 4'b0010, 0, 4'h0, 0,  4'b0010, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h5, 0,  4'b0010, 1, 1, 0, 0);
        addVec(0, 1, 6'b010000, 4'b0100, 1, 4'h1, 0,  4'b0100, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0100, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h8, 1,  4'b0100, 1, 1, 1, 0);
        addVec(0, 1, 6'b010000, 4'b0000, 1, 4'h9, 0,  4'b0100, 0, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0100, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h0, 0,  4'b0100, 0, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0100, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'hC, 0,  4'b0100, 0, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0100, 0, 0, 0, 0);
        addVec(0, 1, 6'b010000, 4'b0001, 1, 4'h7, 0,  4'b0001, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h2, 1,  4'b0001, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'hB, 0,  4'b0001, 0, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'hD, 0,  4'b0001, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'hE, 1,  4'b0001, 1, 1, 0, 0);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'hF, 1,  4'b0001, 0, 1, 1, 0);
        addVec(0, 1, 6'b010000, 4'b1111, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h8, 0,  4'b0001, 1, 1, 0, 0);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h8, 0,  4'b0001, 0, 0, 0, 1);
        addVec(0, 0, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 1);
        addVec(0, 0, 6'b000000, 4'b0000, 1, 4'h8, 0,  4'b0001, 1, 1, 0, 1);
        addVec(0, 1, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0001, 0, 0, 0, 1);
        addVec(1, 0, 6'b000000, 4'b0000, 0, 4'h0, 0,  4'b0000, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].av, vecs[i].op, vecs[i].aicc,
                          vecs[i].bv, vecs[i].cond, vecs[i].ann);
            checkOutput($sformatf("vec%0d", i), vecs[i].eIcc, vecs[i].eTaken,
                        vecs[i].ePend, vecs[i].eSq, vecs[i].eDcti);
        end

        // Annulled not-taken branch held across three bubbles, then the squashed slot op.
        applyStimulus(0, 0, 6'b000000, 4'b0000, 1, 4'h1, 1);
        checkOutput("bubbleBranch", 4'b0000, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 6'b000000, 4'b0000, 0, 4'h0, 0);
            checkOutput($sformatf("bubble%0d", k), 4'b0000, 0, 1, 1, 0);
        end
        applyStimulus(0, 1, 6'b010000, 4'b1111, 0, 4'h0, 0);
        checkOutput("bubbleSlot", 4'b0000, 0, 0, 0, 0);

        // Reset while waiting for the slot abandons it; the next ALU op writes normally.
        applyStimulus(0, 0, 6'b000000, 4'b0000, 1, 4'h8, 1);
        checkOutput("midResetBranch", 4'b0000, 1, 1, 1, 0);
        applyStimulus(0, 0, 6'b000000, 4'b0000, 0, 4'h0, 0);
        checkOutput("midResetBubble", 4'b0000, 0, 1, 1, 0);
        applyStimulus(1, 0, 6'b000000, 4'b0000, 0, 4'h0, 0);
        checkOutput("midResetApplied", 4'b0000, 0, 0, 0, 0);
        applyStimulus(0, 0, 6'b000000, 4'b0000, 0, 4'h0, 0);
        checkOutput("midResetIdle", 4'b0000, 0, 0, 0, 0);
        applyStimulus(0, 1, 6'b010000, 4'b0011, 0, 4'h0, 0);
        checkOutput("postResetWrite", 4'b0011, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
